// File: rtl/struct_s.sv
// Shared stats types and constants for the stats pipeline blocks.
package struct_s;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] val;
  } stats_t;

  localparam int unsigned NUM_REG            = 256;
  localparam logic [7:0]  REG_NOTUSED        = 8'hFF;
  localparam int unsigned STATS_INTERVAL     = 256;
  localparam int unsigned STATS_MERGE_MAX_IN = 16;

endpackage

// File: rtl/avl_stream_if.sv
// Minimal Avalon-ST interface: valid/ready handshake with sop/eop framing.
interface avl_stream_if #(
  parameter int unsigned DataW = $bits(struct_s::stats_t)
);
  logic             valid;
  logic             ready;
  logic             sop;
  logic             eop;
  logic [DataW-1:0] data;

  modport tx (output valid, sop, eop, data, input ready);
  modport rx (input valid, sop, eop, data, output ready);
endinterface

// File: rtl/stats_skid_fifo.sv
// Two-entry in-order stats_t FIFO; caller must not push when full_o is high.
module stats_skid_fifo
  import struct_s::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  logic   pop_i,
  input  stats_t wdata_i,
  output stats_t rdata_o,
  output logic   full_o,
  output logic   nonempty_o
);

  stats_t     mem_q [2];
  stats_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push_i && pop_i) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata_o    = mem_q[rd_ptr_q];
  assign full_o     = (cnt_q == 2'd2);
  assign nonempty_o = (cnt_q != 2'd0);

endmodule

// File: rtl/stats_merge_avlstrm.sv
// Round-robin merge of NUM_IN stats streams into one registered output stream.
// Define STATS_MERGE_SELF_STAT_EN to add a periodic self-stat slot to the ring.
module stats_merge_avlstrm
  import struct_s::*;
#(
  parameter int unsigned NUM_IN    = 4,
  parameter logic [7:0]  SELF_ADDR = 8'd250
) (
  input logic      Clk,
  input logic      Rst,
  avl_stream_if.rx stats_in [NUM_IN],
  avl_stream_if.tx stats_out
);

`ifdef STATS_MERGE_SELF_STAT_EN
  localparam int unsigned Ring = NUM_IN + 1;
`else
  localparam int unsigned Ring = NUM_IN;
`endif
  localparam int unsigned PtrW = $clog2(Ring);

  if (NUM_IN < 2 || NUM_IN > STATS_MERGE_MAX_IN || SELF_ADDR == REG_NOTUSED) begin : g_param_err
    $error("stats_merge_avlstrm: bad NUM_IN or SELF_ADDR");
  end

  logic [NUM_IN-1:0] fifo_full, fifo_ne, push, pop;
  stats_t            fifo_rdata [NUM_IN];
  logic [Ring-1:0]   req;
  logic              grant, issue, self_grant;
  logic [PtrW-1:0]   grant_idx, rr_ptr_q, rr_ptr_d;
  int unsigned       cand;
  logic              out_vld_q, out_vld_d;
  stats_t            out_data_q, out_data_d, self_beat;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
    stats_t in_data;
    assign in_data            = stats_t'(stats_in[gi].data);
    assign stats_in[gi].ready = !fifo_full[gi];
    // REG_NOTUSED beats are handshaken but dropped here.
    assign push[gi] = stats_in[gi].valid && !fifo_full[gi] && (in_data.addr != REG_NOTUSED);

    stats_skid_fifo u_fifo (
      .clk_i      (Clk),
      .rst_i      (Rst),
      .push_i     (push[gi]),
      .pop_i      (pop[gi]),
      .wdata_i    (in_data),
      .rdata_o    (fifo_rdata[gi]),
      .full_o     (fifo_full[gi]),
      .nonempty_o (fifo_ne[gi])
    );
  end

  // First requester at or after rr_ptr, wrapping around the ring.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 0; k < Ring; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= Ring) cand -= Ring;
      for (int unsigned j = 0; j < Ring; j++) begin
        if (!grant && req[j] && cand == j) begin
          grant     = 1'b1;
          grant_idx = PtrW'(j);
        end
      end
    end
  end

  assign issue = grant && (!out_vld_q || stats_out.ready);

  always_comb begin
    pop        = '0;
    out_vld_d  = out_vld_q && !stats_out.ready;
    out_data_d = out_data_q;
    rr_ptr_d   = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (issue && grant_idx == PtrW'(i)) begin
        pop[i]     = 1'b1;
        out_data_d = fifo_rdata[i];
      end
    end
    if (self_grant) out_data_d = self_beat;
    if (issue) begin
      out_vld_d = 1'b1;
      rr_ptr_d  = (grant_idx == PtrW'(Ring - 1)) ? '0 : grant_idx + PtrW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

`ifdef STATS_MERGE_SELF_STAT_EN
  localparam int unsigned IntW = $clog2(STATS_INTERVAL);

  logic [31:0]   beat_cnt_q, beat_cnt_d;
  logic [IntW-1:0] ivl_q, ivl_d;
  logic          self_req_q, self_req_d;

  assign req        = {self_req_q, fifo_ne};
  assign self_grant = issue && (grant_idx == PtrW'(NUM_IN));
  assign self_beat  = '{addr: SELF_ADDR, val: beat_cnt_q};

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (out_vld_q && stats_out.ready && beat_cnt_q != 32'hFFFF_FFFF) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
    end
    ivl_d      = (ivl_q == IntW'(STATS_INTERVAL - 1)) ? '0 : ivl_q + IntW'(1);
    self_req_d = self_req_q;
    if (self_grant) self_req_d = 1'b0;
    // A wrap coinciding with a grant re-arms the request.
    if (ivl_q == IntW'(STATS_INTERVAL - 1)) self_req_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      beat_cnt_q <= '0;
      ivl_q      <= '0;
      self_req_q <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      ivl_q      <= ivl_d;
      self_req_q <= self_req_d;
    end
  end
`else
  assign req        = fifo_ne;
  assign self_grant = 1'b0;
  assign self_beat  = '0;
`endif

  assign stats_out.valid = out_vld_q;
  assign stats_out.sop   = out_vld_q;
  assign stats_out.eop   = out_vld_q;
  assign stats_out.data  = out_data_q;

endmodule
